inst_encoder: RTL and testbench

- Inverse of the immediate sign-extension path: packs an operation kind, register fields and a 64-bit sign-extended immediate into a 32-bit LEGv8 instruction word (LDUR/STUR D-format, CBZ CB-format).
- Sits between the test/boot loader and instruction memory, and drives sequential imem write addresses.
- Valid/ready on both sides, range checking of the immediate, and a 2-entry output FIFO.

---
 rtl/leg_pkg.sv | 40 ++++
 rtl/inst_encoder_if.sv | 41 ++++
 rtl/inst_fifo2.sv | 70 +++++++
 rtl/inst_encoder.sv | 112 +++++++++++
 tb/tb_inst_encoder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/leg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leg_pkg
//  Description : Shared LEGv8 encoding definitions. Provides the request
//                operation kinds, the D-format and CB-format opcode
//                constants, and helpers that pack instruction fields into a
//                32-bit word. The encoder and the decoder-side sign-extension
//                path both use these constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package leg_pkg;

    typedef enum logic [1:0] {
        OP_LDUR = 2'b00,
        OP_STUR = 2'b01,
        OP_CBZ  = 2'b10,
        OP_RSVD = 2'b11
    } op_kind_t;

    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;

    // D-format: opcode | imm9 | op2 (always 00 here) | Rn | Rt
    function automatic logic [31:0] pack_d(input logic [10:0] opc,
                                           input logic [8:0]  imm9,
                                           input logic [4:0]  rn,
                                           input logic [4:0]  rt);
        return {opc, imm9, 2'b00, rn, rt};
    endfunction

    // CB-format: opcode | imm19 | Rt
    function automatic logic [31:0] pack_cb(input logic [7:0]  opc,
                                            input logic [18:0] imm19,
                                            input logic [4:0]  rt);
        return {opc, imm19, rt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder_if
//  Description : Request / output bus of the instruction encoder.
//                Request side : req_valid, req_ready, req_op, req_rt,
//                               req_rn, req_imm
//                Output side  : out_valid, out_ready, out_inst, out_addr
//                Status       : err (sticky), err_clr
//                'slave' is the encoder view, 'master' is the loader view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_encoder_if #(
    parameter int ADDR_W = 6
);
    import leg_pkg::*;

    logic              req_valid;
    logic              req_ready;
    op_kind_t          req_op;
    logic [4:0]        req_rt;
    logic [4:0]        req_rn;
    logic [63:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic              err_clr;

    modport slave (
        input  req_valid, req_op, req_rt, req_rn, req_imm, out_ready, err_clr,
        output req_ready, out_valid, out_inst, out_addr, err
    );

    modport master (
        output req_valid, req_op, req_rt, req_rn, req_imm, out_ready, err_clr,
        input  req_ready, out_valid, out_inst, out_addr, err
    );

endinterface
`default_nettype wire

// File: rtl/inst_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fifo2
//  Description : Small synchronous FIFO with valid/ready on both sides.
//                Built for DEPTH = 2 (pointers wrap naturally at a power of
//                two). Write side is ready whenever count < DEPTH; it never
//                looks at the read side, so there is no fall-through when
//                full. Contents reset to zero so the head reads 0 after reset.
//  Ports       : clk, reset (async, active-low)
//                i_wr_valid / o_wr_ready / i_wr_data   - push side
//                o_rd_valid / i_rd_ready / o_rd_data   - pop side
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo2 #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_wr_valid,
    output logic                   o_wr_ready,
    input  wire logic [DATA_W-1:0] i_wr_data,
    output logic                   o_rd_valid,
    input  wire logic              i_rd_ready,
    output logic [DATA_W-1:0]      o_rd_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign o_wr_ready = (r_count < CNT_W'(DEPTH));
    assign o_rd_valid = (r_count != '0);
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign w_push     = i_wr_valid & o_wr_ready;
    assign w_pop      = o_rd_valid & i_rd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder
//  Description : Packs an operation kind, register fields and a 64-bit
//                sign-extended immediate into a LEGv8 instruction word
//                (LDUR/STUR D-format, CBZ CB-format), buffers it in a
//                2-entry FIFO and pairs it with a sequential imem write
//                address that advances on every pop.
//                Out-of-range immediates and the reserved op are consumed
//                without producing output and set a sticky error flag.
//  Ports       : clk   - system clock, rising edge
//                reset - asynchronous, active-low reset
//                bus   - inst_encoder_if.slave (request, output, err)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import leg_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    inst_encoder_if.slave bus
);
    logic [31:0]       w_inst;
    logic              w_legal;
    logic              w_d_fits;
    logic              w_cb_fits;
    logic              w_accept;
    logic              w_push;
    logic              w_reject;
    logic              w_fifo_wr_ready;
    logic              w_pop;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;

    // An immediate fits when every bit above the field is a copy of the
    // field's sign bit.
    assign w_d_fits  = (bus.req_imm[63:8]  == {56{bus.req_imm[8]}});
    assign w_cb_fits = (bus.req_imm[63:18] == {46{bus.req_imm[18]}});

    always_comb begin
        w_inst  = '0;
        w_legal = 1'b0;
        case (bus.req_op)
            OP_LDUR: begin
                w_inst  = pack_d(OPC_LDUR, bus.req_imm[8:0], bus.req_rn, bus.req_rt);
                w_legal = w_d_fits;
            end
            OP_STUR: begin
                w_inst  = pack_d(OPC_STUR, bus.req_imm[8:0], bus.req_rn, bus.req_rt);
                w_legal = w_d_fits;
            end
            OP_CBZ: begin
                w_inst  = pack_cb(OPC_CBZ, bus.req_imm[18:0], bus.req_rt);
                w_legal = w_cb_fits;
            end
            default: begin
                w_inst  = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    // Acceptance depends only on FIFO occupancy, never on out_ready.
    assign w_accept = bus.req_valid & w_fifo_wr_ready;
    assign w_push   = w_accept & w_legal;
    assign w_reject = w_accept & ~w_legal;
    assign w_pop    = bus.out_valid & bus.out_ready;

    inst_fifo2 #(
        .DATA_W (32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_valid (w_push),
        .o_wr_ready (w_fifo_wr_ready),
        .i_wr_data  (w_inst),
        .o_rd_valid (bus.out_valid),
        .i_rd_ready (bus.out_ready),
        .o_rd_data  (bus.out_inst)
    );

    // The write address only advances when an entry leaves the FIFO, so a
    // rejected request never consumes an address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
        end else if (w_pop) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // Setting wins over clearing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_reject) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.req_ready = w_fifo_wr_ready;
    assign bus.out_addr  = r_addr;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_encoder
//  Description : Self-checking bench for inst_encoder. A queue-based model
//                computes each instruction word arithmetically from the
//                field layout and tracks occupancy, write address and the
//                sticky error flag. Directed cases plus randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;
    import leg_pkg::*;

    localparam int ADDR_W = 6;
    localparam int NADDR  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference state
    logic [31:0] m_q[$];
    int          m_addr;
    bit          m_err;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Instruction word from field weights; returns 0 when the request is illegal.
    function automatic bit ref_enc(input int op, input int rt, input int rn,
                                   input longint imm, output logic [31:0] inst);
        longint unsigned w;
        inst = '0;
        case (op)
            0, 1: begin
                if (imm < -256 || imm > 255) return 1'b0;
                w = ((op == 0) ? 64'h7C2 : 64'h7C0) * 64'd2097152
                    + longint'(imm & 511) * 64'd4096 + rn * 32 + rt;
                inst = w[31:0];
                return 1'b1;
            end
            2: begin
                if (imm < -262144 || imm > 262143) return 1'b0;
                w = 64'hB4 * 64'd16777216 + longint'(imm & 524287) * 32 + rt;
                inst = w[31:0];
                return 1'b1;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic compare();
        check("req_ready", bus.req_ready, m_q.size() < 2);
        check("out_valid", bus.out_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("out_inst", bus.out_inst, m_q[0]);
        check("out_addr", bus.out_addr, m_addr);
        check("err", bus.err, m_err);
    endtask

    task automatic drive(input bit v, input int op, input int rt, input int rn,
                         input longint imm, input bit ordy, input bit clr);
        logic [31:0] inst;
        bit legal, accept, pop;
        bus.req_valid = v;
        bus.req_op    = op_kind_t'(op[1:0]);
        bus.req_rt    = 5'(rt);
        bus.req_rn    = 5'(rn);
        bus.req_imm   = imm;
        bus.out_ready = ordy;
        bus.err_clr   = clr;
        legal  = ref_enc(op, rt, rn, imm, inst);
        accept = v && (m_q.size() < 2);
        pop    = (m_q.size() != 0) && ordy;
        if (pop) begin
            void'(m_q.pop_front());
            m_addr = (m_addr + 1) % NADDR;
        end
        if (accept && legal) m_q.push_back(inst);
        if (accept && !legal) m_err = 1'b1;
        else if (clr)         m_err = 1'b0;
    endtask

    // Check the state left by the previous edge, then present new inputs.
    task automatic step(input bit v, input int op, input int rt, input int rn,
                        input longint imm, input bit ordy, input bit clr);
        @(posedge clk);
        #1;
        compare();
        drive(v, op, rt, rn, imm, ordy, clr);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 0, 0, 0, 0, ordy, 1'b0);
    endtask

    // Reset lands mid-cycle; outputs must clear without waiting for a clock.
    task automatic apply_reset();
        #2;
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_addr",  bus.out_addr,  '0);
        check("rst_out_inst",  bus.out_inst,  '0);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_err",       bus.err,       1'b0);
        m_q.delete();
        m_addr = 0;
        m_err  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic longint rand_imm();
        longint picks[8] = '{-256, 255, 256, -257, -262144, 262143, 262144, -262145};
        case ($urandom_range(0, 4))
            0: return longint'($urandom_range(0, 511)) - 256;
            1: return picks[$urandom_range(0, 7)];
            2: return longint'($urandom_range(0, 524287)) - 262144;
            3: return {$urandom, $urandom};
            default: return longint'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = OP_LDUR;
        bus.req_rt    = '0;
        bus.req_rn    = '0;
        bus.req_imm   = '0;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        m_addr = 0;
        m_err  = 1'b0;
        apply_reset();

        // LDUR rt=1 rn=2 imm=-8
        step(1'b1, 0, 1, 2, -8, 1'b1, 1'b0);
        idle(1'b1);
        check("ldur_inst", bus.out_inst, 32'hF85F8041);
        check("ldur_addr", bus.out_addr, 0);

        // STUR then CBZ, streaming
        step(1'b1, 1, 0, 1, 0, 1'b1, 1'b0);
        step(1'b1, 2, 3, 0, 4, 1'b1, 1'b0);
        check("stur_inst", bus.out_inst, 32'hF8000020);
        idle(1'b1);
        check("cbz_inst", bus.out_inst, 32'hB4000083);

        // Most negative CBZ offset
        step(1'b1, 2, 0, 0, -262144, 1'b1, 1'b0);
        idle(1'b1);
        check("cbz_min_inst", bus.out_inst, 32'hB4800000);

        // Out-of-range LDUR: consumed, no output, err set; then clear
        idle(1'b1);
        step(1'b1, 0, 1, 1, 256, 1'b1, 1'b0);
        idle(1'b1);
        check("illegal_err", bus.err, 1'b1);
        check("illegal_no_out", bus.out_valid, 1'b0);
        step(1'b1, 1, 4, 5, 16, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(1'b1);
        check("err_cleared", bus.err, 1'b0);

        // Backpressure: two accepted, third waits until after the first pop
        step(1'b1, 0, 1, 0, 1, 1'b0, 1'b0);
        step(1'b1, 0, 2, 0, 2, 1'b0, 1'b0);
        step(1'b1, 0, 3, 0, 3, 1'b0, 1'b0);
        check("full_not_ready", bus.req_ready, 1'b0);
        step(1'b1, 0, 3, 0, 3, 1'b0, 1'b0);
        step(1'b1, 0, 3, 0, 3, 1'b1, 1'b0);
        step(1'b1, 0, 3, 0, 3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Long stream to wrap the address counter
        for (int i = 0; i < NADDR + 4; i++) step(1'b1, 1, i % 32, 7, i % 200, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 8, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 rand_imm(), $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
        end

        // Reset with two entries pending
        step(1'b1, 0, 5, 6, 7, 1'b0, 1'b0);
        step(1'b1, 2, 8, 0, 9, 1'b0, 1'b0);
        idle(1'b0);
        check("pre_rst_full", bus.req_ready, 1'b0);
        apply_reset();
        step(1'b1, 2, 1, 0, -1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
